// File: rtl/led_scanner.sv
// HUB75 64x64 1/32-scan engine: issues painter coordinates, pairs returned pixels and drives shift/latch/blank.
// Optional LED_SCANNER_GHOST_GUARD_EN stretches BLANK to 2 cycles and adds a blanked cycle after LATCH.
module led_scanner #(
    parameter int DELAY          = 3,
    parameter int SUBFRAMES      = 256,
    parameter int DISPLAY_CYCLES = 64
) (
    input  logic       clk,
    input  logic       resetn,
    output logic [9:0] frame,
    output logic [7:0] subframe,
    output logic [5:0] x,
    output logic [5:0] y,
    input  logic [2:0] rgb,
    output logic       r0,
    output logic       g0,
    output logic       b0,
    output logic       r1,
    output logic       g1,
    output logic       b1,
    output logic [4:0] addr,
    output logic       sclk,
    output logic       latch,
    output logic       blank
);

    typedef enum logic [2:0] {
        S_SHIFT,
        S_DRAIN,
        S_BLANK,
        S_LATCH,
        S_GUARD,
        S_DISPLAY
    } state_t;

    localparam logic [15:0] DC_LAST = 16'(DISPLAY_CYCLES - 1);
    localparam logic [7:0]  SF_LAST = 8'(SUBFRAMES - 1);

    state_t            state;
    logic [6:0]        k;
    logic [4:0]        row;
    logic [15:0]       dcnt;
    logic [2:0]        hold;
    logic [DELAY-1:0]  tag_v;
    logic [DELAY-1:0]  tag_h;
    logic [6:0]        k_nxt;
    logic [4:0]        row_nxt;
`ifdef LED_SCANNER_GHOST_GUARD_EN
    logic              bcnt;
`endif

    assign k_nxt   = k + 7'd1;
    assign row_nxt = row + 5'd1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= S_SHIFT;
            k        <= '0;
            row      <= '0;
            dcnt     <= '0;
            hold     <= '0;
            tag_v    <= '0;
            tag_h    <= '0;
            frame    <= '0;
            subframe <= '0;
            x        <= '0;
            y        <= '0;
            r0       <= 1'b0;
            g0       <= 1'b0;
            b0       <= 1'b0;
            r1       <= 1'b0;
            g1       <= 1'b0;
            b1       <= 1'b0;
            addr     <= '0;
            sclk     <= 1'b0;
            latch    <= 1'b0;
            blank    <= 1'b1;
`ifdef LED_SCANNER_GHOST_GUARD_EN
            bcnt     <= 1'b0;
`endif
        end else begin
            // Stage d of the tag pipe describes the coordinate issued d cycles ago.
            tag_v <= (tag_v << 1) | DELAY'(state == S_SHIFT);
            tag_h <= (tag_h << 1) | DELAY'(k[0]);

            sclk  <= 1'b0;
            latch <= 1'b0;
            if (tag_v[DELAY-1]) begin
                if (!tag_h[DELAY-1]) begin
                    hold <= rgb;
                end else begin
                    r0   <= hold[0];
                    g0   <= hold[1];
                    b0   <= hold[2];
                    r1   <= rgb[0];
                    g1   <= rgb[1];
                    b1   <= rgb[2];
                    sclk <= 1'b1;
                end
            end

            case (state)
                S_SHIFT: begin
                    if (k == 7'd127) begin
                        k     <= '0;
                        state <= S_DRAIN;
                    end else begin
                        k <= k_nxt;
                        x <= k_nxt[6:1];
                        y <= {k_nxt[0], row};
                    end
                end
                S_DRAIN: begin
                    // Once the pipe is empty the final sclk pulse is high now and ends at this edge.
                    if (tag_v == '0) begin
                        state <= S_BLANK;
`ifdef LED_SCANNER_GHOST_GUARD_EN
                        bcnt  <= 1'b0;
`endif
                    end
                end
                S_BLANK: begin
`ifdef LED_SCANNER_GHOST_GUARD_EN
                    if (!bcnt) begin
                        bcnt <= 1'b1;
                    end else begin
                        addr  <= row;
                        latch <= 1'b1;
                        state <= S_LATCH;
                    end
`else
                    addr  <= row;
                    latch <= 1'b1;
                    state <= S_LATCH;
`endif
                end
                S_LATCH: begin
`ifdef LED_SCANNER_GHOST_GUARD_EN
                    state <= S_GUARD;
`else
                    blank <= 1'b0;
                    dcnt  <= '0;
                    state <= S_DISPLAY;
`endif
                end
                S_GUARD: begin
                    blank <= 1'b0;
                    dcnt  <= '0;
                    state <= S_DISPLAY;
                end
                S_DISPLAY: begin
                    if (dcnt == DC_LAST) begin
                        blank <= 1'b1;
                        state <= S_SHIFT;
                        row   <= row_nxt;
                        x     <= '0;
                        y     <= {1'b0, row_nxt};
                        if (row == 5'd31) begin
                            if (subframe == SF_LAST) begin
                                subframe <= '0;
                                frame    <= frame + 10'd1;
                            end else begin
                                subframe <= subframe + 8'd1;
                            end
                        end
                    end else begin
                        dcnt <= dcnt + 16'd1;
                    end
                end
                default: begin
                    blank <= 1'b1;
                    state <= S_SHIFT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_scanner.sv
// Directed bench for led_scanner: a row-position model predicts every output each cycle,
// a painter model returns rgb={x[0],y[5],1} DELAY cycles after each coordinate.
`timescale 1ns/1ps
module tb_led_scanner;
    localparam int DELAY          = 3;
    localparam int SUBFRAMES      = 4;
    localparam int DISPLAY_CYCLES = 16;
`ifdef LED_SCANNER_GHOST_GUARD_EN
    localparam int GUARD       = 1;
    localparam int LIT_LATCH   = 134;
    localparam int LIT_DISP0   = 136;
    localparam int LIT_PERIOD  = 152;
`else
    localparam int GUARD       = 0;
    localparam int LIT_LATCH   = 133;
    localparam int LIT_DISP0   = 134;
    localparam int LIT_PERIOD  = 150;
`endif
    localparam int PERIOD     = 128 + DELAY + 1 + 2 + DISPLAY_CYCLES + 2 * GUARD;
    localparam int LATCH_T    = 128 + DELAY + 2 + GUARD;
    localparam int DISP_T     = PERIOD - DISPLAY_CYCLES;
    localparam int SCLK_FIRST = DELAY + 2;
    localparam int SCLK_LAST  = DELAY + 128;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [9:0] frame;
    logic [7:0] subframe;
    logic [5:0] x;
    logic [5:0] y;
    logic [2:0] rgb;
    logic       r0, g0, b0, r1, g1, b1;
    logic [4:0] addr;
    logic       sclk;
    logic       latch;
    logic       blank;

    int n_checks = 0;
    int n_errors = 0;

    led_scanner #(
        .DELAY(DELAY),
        .SUBFRAMES(SUBFRAMES),
        .DISPLAY_CYCLES(DISPLAY_CYCLES)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .frame(frame),
        .subframe(subframe),
        .x(x),
        .y(y),
        .rgb(rgb),
        .r0(r0),
        .g0(g0),
        .b0(b0),
        .r1(r1),
        .g1(g1),
        .b1(b1),
        .addr(addr),
        .sclk(sclk),
        .latch(latch),
        .blank(blank)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int cyc, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    // Painter: answer for each coordinate appears DELAY cycles after it was issued.
    logic [2:0] hist [0:DELAY];
    always @(posedge clk) begin
        #1;
        for (int i = DELAY; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = {x[0], y[5], 1'b1};
        rgb = hist[DELAY];
    end

    int c = 0;
    int m_row = 0, m_sub = 0, m_frame = 0, m_addr = 0;
    int pulses = 0;
    int prev_addr = 0;

    always @(negedge clk) begin
        int t, ex, ey, col;
        if (!resetn) begin
            c = 0; m_row = 0; m_sub = 0; m_frame = 0; m_addr = 0; pulses = 0; prev_addr = 0;
            chk("rst_frame", c, frame, 0);
            chk("rst_subframe", c, subframe, 0);
            chk("rst_xy", c, {x, y}, 0);
            chk("rst_ctl", c, {addr, sclk, latch, blank}, 1);
            chk("rst_data", c, {r0, g0, b0, r1, g1, b1}, 0);
        end else begin
            t = c % PERIOD;
            if (t == 0 && c != 0) begin
                m_row = (m_row + 1) % 32;
                if (m_row == 0) begin
                    m_sub = (m_sub + 1) % SUBFRAMES;
                    if (m_sub == 0) m_frame = (m_frame + 1) % 1024;
                end
            end
            if (t == LATCH_T) m_addr = m_row;
            if (t < 128) begin
                ex = t / 2;
                ey = (t % 2) * 32 + m_row;
            end else begin
                ex = 63;
                ey = 32 + m_row;
            end
            chk("x", c, x, ex);
            chk("y", c, y, ey);
            chk("sclk", c, sclk,
                (t >= SCLK_FIRST && t <= SCLK_LAST && ((t - DELAY) % 2) == 0) ? 1 : 0);
            chk("latch", c, latch, (t == LATCH_T) ? 1 : 0);
            chk("blank", c, blank, (t >= DISP_T) ? 0 : 1);
            chk("addr", c, addr, m_addr);
            chk("frame", c, frame, m_frame);
            chk("subframe", c, subframe, m_sub);
            if (t >= SCLK_FIRST && t <= SCLK_LAST && ((t - DELAY) % 2) == 0) begin
                col = (t - SCLK_FIRST) / 2;
                chk("upper_rgb", c, {r0, g0, b0}, {1'b1, 1'b0, col[0]});
                chk("lower_rgb", c, {r1, g1, b1}, {1'b1, 1'b1, col[0]});
            end
            if (t >= DISP_T) chk("held_data", c, {r0, g0, b0, r1, g1, b1}, 6'b101111);
            if (sclk) pulses++;
            if (latch) begin
                chk("pulses_per_row", c, pulses, 64);
                pulses = 0;
            end
            if (latch || addr != prev_addr) chk("blank_invariant", c, blank, 1);
            prev_addr = addr;

            if (c == 1) begin
                chk("lit_x1", c, x, 0);
                chk("lit_y1", c, y, 32);
            end
            if (c == 131) chk("lit_last_sclk", c, sclk, 1);
            if (c == 132) chk("lit_sclk_low", c, sclk, 0);
            if (c == LIT_LATCH) chk("lit_latch", c, latch, 1);
            if (c == LIT_DISP0 - 1) chk("lit_blank_pre", c, blank, 1);
            if (c == LIT_DISP0) chk("lit_blank_first", c, blank, 0);
            if (c == LIT_PERIOD - 1) chk("lit_blank_last", c, blank, 0);
            if (c == LIT_PERIOD) chk("lit_row2_start", c, {x, y, 5'd0, blank}, {6'd0, 6'd1, 5'd0, 1'b1});
            if (c == LIT_PERIOD + LIT_LATCH) chk("lit_addr_row2", c, addr, 1);
            if (c == 32 * LIT_PERIOD + 5) chk("lit_sub_after32", c, subframe, 1);
            if (c == 128 * LIT_PERIOD + 5) begin
                chk("lit_sub_after128", c, subframe, 0);
                chk("lit_frame_after128", c, frame, 1);
            end
            if (c == 384 * LIT_PERIOD + 5) chk("lit_frame_wrap", c, frame, 0);
            c++;
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #2 resetn = 1'b1;
        repeat (40) @(posedge clk);
        #2 resetn = 1'b0;
        repeat (2) @(posedge clk);
        #2 resetn = 1'b1;
        // Park frame at 1023 mid-display of the last row of the third frame, then watch it wrap.
        repeat (383 * PERIOD + 140) @(posedge clk);
        #2;
        force dut.frame = 10'd1023;
        m_frame = 1023;
        #1;
        release dut.frame;
        repeat (PERIOD + 20) @(posedge clk);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
